// File: rtl/skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// skid_pipe_reg
//   Two-entry skid pipeline register for a processor stage. Beats carry a
//   program counter, a payload and a bubble (nop) flag. The stage keeps FIFO
//   order across a head entry (driven on out_*) and a skid entry (catches the
//   beat that was in flight when downstream stalled). in_ready and out_valid
//   come from registered occupancy only, so out_ready has no combinational
//   path to in_ready.
//
// Parameters
//   DATA_W     payload width
//   PC_W       program-counter width
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset (highest priority)
//   in_valid   upstream beat present
//   in_ready   stage can take a beat this cycle
//   in_pc      pc of the incoming beat
//   in_data    payload of the incoming beat
//   in_nop     incoming beat is a bubble (payload forced to zero)
//   flush      discard every held beat and the beat on the input
//   out_valid  head beat present
//   out_ready  downstream takes the head beat this cycle
//   out_pc     pc of the head beat (zero when empty)
//   out_data   payload of the head beat (zero when empty)
//   out_nop    head beat is a bubble (zero when empty)
//   count      occupancy, 0..2
// -----------------------------------------------------------------------------
module skid_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_nop,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_nop,
    output logic [1:0]        count
);

    // Stored entries and occupancy.
    logic [PC_W-1:0]   r_head_pc;
    logic [DATA_W-1:0] r_head_data;
    logic              r_head_nop;
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_nop;
    logic [1:0]        r_count;

    // Handshake decode.
    logic              w_accept;
    logic              w_emit;
    logic [DATA_W-1:0] w_in_data;

    // A full stage refuses input; the stage also refuses while held in reset
    // so nothing upstream believes a beat was taken during that cycle.
    assign in_ready  = ~reset & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign count     = r_count;

    assign w_accept  = in_valid & in_ready;
    assign w_emit    = out_valid & out_ready;

    // Bubbles keep their pc for exception/debug tracking but never carry payload.
    assign w_in_data = in_nop ? '0 : in_data;

    // Outputs read as zero whenever no beat is present.
    assign out_pc   = out_valid ? r_head_pc   : '0;
    assign out_data = out_valid ? r_head_data : '0;
    assign out_nop  = out_valid ? r_head_nop  : 1'b0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: both entries are cleared on reset and flush (not just the count),
    // so a stale beat can never leak onto out_* through a later decode bug.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 2'd0;
            r_head_pc   <= '0;
            r_head_data <= '0;
            r_head_nop  <= 1'b0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
            r_skid_nop  <= 1'b0;
        end else if (flush) begin
            // Any emit in this cycle counts as consumed; the input beat is dropped.
            r_count     <= 2'd0;
            r_head_pc   <= '0;
            r_head_data <= '0;
            r_head_nop  <= 1'b0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
            r_skid_nop  <= 1'b0;
        end else if (w_accept && w_emit) begin
            // Only reachable at count=1: the new beat replaces the departing
            // head directly, the skid entry stays empty and count is unchanged.
            r_head_pc   <= in_pc;
            r_head_data <= w_in_data;
            r_head_nop  <= in_nop;
        end else if (w_emit) begin
            r_count <= r_count - 2'd1;
            if (r_count == 2'd2) begin
                // Skid entry advances to head.
                r_head_pc   <= r_skid_pc;
                r_head_data <= r_skid_data;
                r_head_nop  <= r_skid_nop;
            end else begin
                r_head_pc   <= '0;
                r_head_data <= '0;
                r_head_nop  <= 1'b0;
            end
            r_skid_pc   <= '0;
            r_skid_data <= '0;
            r_skid_nop  <= 1'b0;
        end else if (w_accept) begin
            r_count <= r_count + 2'd1;
            if (r_count == 2'd0) begin
                r_head_pc   <= in_pc;
                r_head_data <= w_in_data;
                r_head_nop  <= in_nop;
            end else begin
                // Head is stalled: park the new beat behind it.
                r_skid_pc   <= in_pc;
                r_skid_data <= w_in_data;
                r_skid_nop  <= in_nop;
            end
        end
    end

endmodule

// File: doc/skid_pipe_reg.md
SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the stage payload (operands, immediate, register indices packed by the instantiating stage).
REQ-002 Parameter PC_W, default 32, width of the program-counter field carried alongside the payload.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  stage can accept a beat this cycle.
REQ-007 in_pc  input  PC_W  program counter of the incoming beat.
REQ-008 in_data  input  DATA_W  payload of the incoming beat.
REQ-009 in_nop  input  1  incoming beat is a bubble: payload zeroed, pc kept.
REQ-010 flush  input  1  discard all held beats.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts the beat this cycle.
REQ-013 out_pc  output  PC_W  program counter of the head beat.
REQ-014 out_data  output  DATA_W  payload of the head beat.
REQ-015 out_nop  output  1  head beat is a bubble.
REQ-016 count  output  2  occupancy, 0..2.

Function
REQ-017 Storage SHALL be two entries (head, skid) with FIFO order; each entry holds pc, data, nop flag.
REQ-018 Accept SHALL occur on in_valid & in_ready; emit SHALL occur on out_valid & out_ready.
REQ-019 in_ready SHALL equal (count < 2), decoded from registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0), decoded from registered state only.
REQ-021 Latency: a beat accepted at edge N into an empty stage SHALL appear on out_* after edge N (one cycle).
REQ-022 An accepted beat with in_nop=1 SHALL be stored with data = 0, nop = 1, and pc = in_pc unchanged.
REQ-023 An accepted beat with in_nop=0 SHALL be stored with data = in_data, pc = in_pc, nop = 0.
REQ-024 Count update: accept only -> +1; emit only -> -1; accept and emit -> unchanged.
REQ-025 count=1, accept and emit on the same edge: the incoming beat SHALL become the head; the skid entry SHALL remain empty.
REQ-026 count=2, emit: the skid entry SHALL move to head, count -> 1; no accept is possible (in_ready=0).
REQ-027 count=1, accept without emit: the incoming beat SHALL go to the skid entry; head and out_* SHALL be unchanged.
REQ-028 While out_valid=1 and out_ready=0, out_pc, out_data and out_nop SHALL hold stable.
REQ-029 While out_valid=0, out_pc, out_data and out_nop SHALL be driven to 0.
REQ-030 flush=1 SHALL clear both entries at the edge (count -> 0); a beat presented on the input in that cycle SHALL be dropped; flush SHALL take priority over accept and emit.
REQ-031 An emit handshake in a flush cycle SHALL be treated as consumed by downstream; the stage SHALL NOT re-present it.
REQ-032 Accept at count=2 and emit at count=0 are impossible by construction, so no overflow or underflow SHALL occur.

Reset
REQ-033 reset=1 at an edge SHALL set count=0, out_valid=0, out_pc=0, out_data=0, out_nop=0 and clear both entries.
REQ-034 in_ready SHALL be 0 while reset is asserted and 1 from the first cycle after reset deasserts.
REQ-035 reset SHALL take priority over flush, accept and emit, including mid-transfer with count=2.

Verification
REQ-036 After reset, accept pc=0x100 data=0xDEADBEEF with out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_data=0xDEADBEEF, count=1.
REQ-037 Accept pc=0x104 data=0x1234 with in_nop=1 -> out_pc=0x104, out_data=0, out_nop=1.
REQ-038 Hold out_ready=0, push A (pc 0x10) then B (pc 0x14) -> count=2, in_ready=0, out_pc stays 0x10; raise out_ready -> A, then B, in order, with no loss.
REQ-039 At count=1, accept C (pc 0x20) while emitting the head on the same edge -> count stays 1, out_pc=0x20 next cycle.
REQ-040 At count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1; the dropped beat never appears on the output.
REQ-041 Assert reset mid-stream at count=2 -> next cycle all outputs 0; in_ready=0 while reset is held, then 1 after release.
